// File: rtl/spi_adi_if.sv
// Pin-level bundle of the 3/4-wire ADI-style SPI link.
// The master drives clock, enable and data-in; the slave drives data-out and its enable.
interface spi_adi_if;
    logic spi_clk;
    logic spi_enb;
    logic spi_di;
    logic spi_do;
    logic spi_do_oe;

    modport master (
        output spi_clk,
        output spi_enb,
        output spi_di,
        input  spi_do,
        input  spi_do_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_enb,
        input  spi_di,
        output spi_do,
        output spi_do_oe
    );
endinterface

// File: rtl/spi_adi_slave.sv
// ADI-style SPI responder emulating an 8-bit register map.
// SPI pins are oversampled on clk; 24-bit frames {R/W, 5 x, addr[9:0], data[7:0]}.
module spi_adi_slave #(
    parameter int REG_DEPTH = 256,
    parameter int SYNC_STG  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_adi_if.slave   spi,
    output logic       reg_wr_vld,
    output logic [9:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    input  logic [9:0] usr_rd_addr,
    output logic [7:0] usr_rd_data
);

    localparam int          AW      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [10:0] DEPTH_L = 11'(REG_DEPTH);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } state_t;

    // Synchronisers reset to 0 so WAIT_CS only leaves on a genuine CS-high.
    logic [SYNC_STG-1:0] sclk_sync_reg;
    logic [SYNC_STG-1:0] enb_sync_reg;
    logic [SYNC_STG-1:0] di_sync_reg;
    logic                sclk_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            enb_sync_reg  <= '0;
            di_sync_reg   <= '0;
            sclk_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STG-2:0], spi.spi_clk};
            enb_sync_reg  <= {enb_sync_reg[SYNC_STG-2:0],  spi.spi_enb};
            di_sync_reg   <= {di_sync_reg[SYNC_STG-2:0],   spi.spi_di};
            sclk_prev_reg <= sclk_sync_reg[SYNC_STG-1];
        end
    end

    logic sclk_s;
    logic enb_s;
    logic di_s;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s    = sclk_sync_reg[SYNC_STG-1];
    assign enb_s     = enb_sync_reg[SYNC_STG-1];
    assign di_s      = di_sync_reg[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;

    state_t      state_reg;
    logic [4:0]  bit_cnt_reg;
    logic [15:0] instr_reg;
    logic [7:0]  shreg_reg;
    logic        spi_do_reg;
    logic        spi_do_oe_reg;

    logic [7:0]  bank [REG_DEPTH];

    logic        addr_ok;
    logic        usr_ok;
    logic        commit;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_byte;

    assign addr_ok = ({1'b0, instr_reg[9:0]} < DEPTH_L);
    assign usr_ok  = ({1'b0, usr_rd_addr} < DEPTH_L);
    assign wr_byte = {shreg_reg[6:0], di_s};
    assign rd_byte = addr_ok ? bank[instr_reg[AW-1:0]] : 8'h00;
    // The 24th rising edge wins over a simultaneous CS rise, so commit ignores enb.
    assign commit  = (state_reg == WDATA) && sclk_rise && (bit_cnt_reg == 5'd23) && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                bank[i] <= 8'h00;
            end
        end else if (commit) begin
            bank[instr_reg[AW-1:0]] <= wr_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_rd_data <= 8'h00;
        end else begin
            usr_rd_data <= usr_ok ? bank[usr_rd_addr[AW-1:0]] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= WAIT_CS;
            bit_cnt_reg   <= '0;
            instr_reg     <= '0;
            shreg_reg     <= '0;
            spi_do_reg    <= 1'b0;
            spi_do_oe_reg <= 1'b0;
            reg_wr_vld    <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
        end else begin
            reg_wr_vld <= commit;
            if (commit) begin
                reg_wr_addr <= instr_reg[9:0];
                reg_wr_data <= wr_byte;
            end

            case (state_reg)
                WAIT_CS: begin
                    if (enb_s) state_reg <= IDLE;
                end
                IDLE: begin
                    bit_cnt_reg   <= '0;
                    spi_do_reg    <= 1'b0;
                    spi_do_oe_reg <= 1'b0;
                    if (!enb_s) state_reg <= CMD;
                end
                CMD: begin
                    if (enb_s) begin
                        state_reg     <= IDLE;
                        bit_cnt_reg   <= '0;
                        spi_do_reg    <= 1'b0;
                        spi_do_oe_reg <= 1'b0;
                    end else if (sclk_rise) begin
                        instr_reg   <= {instr_reg[14:0], di_s};
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        // instr_reg[14] becomes the R/W bit once this edge shifts in
                        if (bit_cnt_reg == 5'd15) state_reg <= instr_reg[14] ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (sclk_rise && bit_cnt_reg == 5'd23) begin
                        bit_cnt_reg <= 5'd24;
                        state_reg   <= DONE;
                    end else if (enb_s) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                    end else if (sclk_rise) begin
                        shreg_reg   <= wr_byte;
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end
                RDATA: begin
                    if (sclk_rise && bit_cnt_reg == 5'd23) begin
                        bit_cnt_reg <= 5'd24;
                        state_reg   <= DONE;
                    end else if (enb_s) begin
                        state_reg     <= IDLE;
                        bit_cnt_reg   <= '0;
                        spi_do_reg    <= 1'b0;
                        spi_do_oe_reg <= 1'b0;
                    end else if (sclk_rise) begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end else if (sclk_fall) begin
                        if (!spi_do_oe_reg) begin
                            shreg_reg     <= rd_byte;
                            spi_do_reg    <= rd_byte[7];
                            spi_do_oe_reg <= 1'b1;
                        end else begin
                            shreg_reg  <= {shreg_reg[6:0], 1'b0};
                            spi_do_reg <= shreg_reg[6];
                        end
                    end
                end
                DONE: begin
                    if (enb_s) begin
                        state_reg     <= IDLE;
                        bit_cnt_reg   <= '0;
                        spi_do_reg    <= 1'b0;
                        spi_do_oe_reg <= 1'b0;
                    end else if (sclk_fall) begin
                        spi_do_reg    <= 1'b0;
                        spi_do_oe_reg <= 1'b0;
                    end
                end
                default: state_reg <= WAIT_CS;
            endcase
        end
    end

    assign spi.spi_do    = spi_do_reg;
    assign spi.spi_do_oe = spi_do_oe_reg;

endmodule

// File: tb/tb_spi_adi_slave.sv
// Scoreboard bench for spi_adi_slave: tasks push expectations, monitors pop and compare.
// A 512-entry bank makes 0x155 and 0x1FF valid while 0x200 and 0x3FF are out of range.
module tb_spi_adi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reg_wr_vld;
    logic [9:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [9:0] usr_rd_addr;
    logic [7:0] usr_rd_data;

    always #5 clk = ~clk;

    spi_adi_if spi_bus ();

    spi_adi_slave #(
        .REG_DEPTH (512),
        .SYNC_STG  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi_bus),
        .reg_wr_vld  (reg_wr_vld),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .usr_rd_addr (usr_rd_addr),
        .usr_rd_data (usr_rd_data)
    );

    int          checks = 0;
    int          errors = 0;
    logic [17:0] wr_q [$];
    logic        bit_q [$];
    logic [7:0]  ur_q [$];
    logic        samp = 1'b0;
    logic        samp_q = 1'b0;
    logic        usr_req = 1'b0;
    logic        usr_vld = 1'b0;
    logic        rw_watch = 1'b0;
    logic [7:0]  rw_old = 8'h00;
    logic [7:0]  rw_new = 8'h00;
    logic [17:0] wexp;
    logic        bexp;
    logic [7:0]  uexp;

    always @(posedge clk) begin
        samp_q  <= samp;
        usr_vld <= usr_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Write-strobe monitor, with optional same-clock local-read ordering check.
    always @(negedge clk) begin
        if (reg_wr_vld === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=addr 0x%0h data 0x%0h required=no strobe",
                         reg_wr_addr, reg_wr_data);
            end else begin
                wexp = wr_q.pop_front();
                check("wr_addr", {22'b0, reg_wr_addr}, {22'b0, wexp[17:8]});
                check("wr_data", {24'b0, reg_wr_data}, {24'b0, wexp[7:0]});
                if (rw_watch) begin
                    check("same_clk_old", {24'b0, usr_rd_data}, {24'b0, rw_old});
                    @(negedge clk);
                    check("same_clk_new", {24'b0, usr_rd_data}, {24'b0, rw_new});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (samp_q) begin
            if (bit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spi_do_extra actual=sample required=empty queue");
            end else begin
                bexp = bit_q.pop_front();
                check("spi_do", {31'b0, spi_bus.spi_do}, {31'b0, bexp});
                check("spi_do_oe", {31'b0, spi_bus.spi_do_oe}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (usr_vld) begin
            if (ur_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL usr_rd_extra actual=0x%0h required=empty queue", usr_rd_data);
            end else begin
                uexp = ur_q.pop_front();
                check("usr_rd_data", {24'b0, usr_rd_data}, {24'b0, uexp});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Half period of spi_clk is 16 clk; read bits are sampled mid high phase.
    task automatic clock_bits(input logic [23:0] f, input int nbits, input bit rd);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.spi_di = f[23-i];
            wait_clk(16);
            spi_bus.spi_clk = 1'b1;
            wait_clk(8);
            if (rd && i >= 16) begin
                samp = 1'b1;
                wait_clk(1);
                samp = 1'b0;
                wait_clk(7);
            end else begin
                wait_clk(8);
            end
            spi_bus.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [23:0] f, input int nbits, input bit rd);
        spi_bus.spi_enb = 1'b0;
        wait_clk(16);
        clock_bits(f, nbits, rd);
        wait_clk(16);
        spi_bus.spi_enb = 1'b1;
        wait_clk(32);
    endtask

    task automatic spi_read(input logic [23:0] f, input logic [7:0] exp);
        for (int i = 7; i >= 0; i--) bit_q.push_back(exp[i]);
        spi_frame(f, 24, 1'b1);
        check("oe_after_read", {31'b0, spi_bus.spi_do_oe}, 32'd0);
    endtask

    task automatic usr_read(input logic [9:0] addr, input logic [7:0] exp);
        usr_rd_addr = addr;
        usr_req = 1'b1;
        ur_q.push_back(exp);
        wait_clk(1);
        usr_req = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        spi_bus.spi_clk = 1'b0;
        spi_bus.spi_enb = 1'b1;
        spi_bus.spi_di  = 1'b0;
        usr_rd_addr     = 10'h000;
        wait_clk(4);
        check("rst_spi_do", {31'b0, spi_bus.spi_do}, 32'd0);
        check("rst_spi_do_oe", {31'b0, spi_bus.spi_do_oe}, 32'd0);
        check("rst_wr_vld", {31'b0, reg_wr_vld}, 32'd0);
        check("rst_wr_addr", {22'b0, reg_wr_addr}, 32'd0);
        check("rst_wr_data", {24'b0, reg_wr_data}, 32'd0);
        check("rst_usr_rd", {24'b0, usr_rd_data}, 32'd0);
        rst_n = 1'b1;
        wait_clk(8);

        // Basic write and read-back over both ports
        wr_q.push_back({10'h155, 8'hA5});
        spi_frame(24'h8155A5, 24, 1'b0);
        usr_read(10'h155, 8'hA5);
        spi_read(24'h015500, 8'hA5);

        // Out-of-range write/read, range boundary, don't-care instruction bits
        spi_frame(24'h83FF3C, 24, 1'b0);
        spi_read(24'h03FF00, 8'h00);
        usr_read(10'h3FF, 8'h00);
        wr_q.push_back({10'h1FF, 8'hAA});
        spi_frame(24'h81FFAA, 24, 1'b0);
        spi_frame(24'h82005A, 24, 1'b0);
        usr_read(10'h1FF, 8'hAA);
        usr_read(10'h200, 8'h00);
        wr_q.push_back({10'h009, 8'h11});
        spi_frame(24'hFC0911, 24, 1'b0);
        spi_read(24'h7C0900, 8'h11);

        // Aborted frame, then a clean one
        spi_frame(24'h8002EE, 12, 1'b0);
        usr_read(10'h002, 8'h00);
        wr_q.push_back({10'h001, 8'h07});
        spi_frame(24'h800107, 24, 1'b0);

        // Back-to-back writes; second one checks same-clock local read ordering
        wr_q.push_back({10'h010, 8'h7F});
        spi_frame(24'h80107F, 24, 1'b0);
        usr_rd_addr = 10'h010;
        rw_old   = 8'h7F;
        rw_new   = 8'h80;
        rw_watch = 1'b1;
        wr_q.push_back({10'h010, 8'h80});
        spi_frame(24'h801080, 24, 1'b0);
        rw_watch = 1'b0;
        usr_read(10'h010, 8'h80);

        // Reset mid-frame with CS held low; following clocks must be ignored
        spi_bus.spi_enb = 1'b0;
        wait_clk(16);
        clock_bits(24'h8044CC, 8, 1'b0);
        rst_n = 1'b0;
        wait_clk(3);
        check("mid_rst_wr_addr", {22'b0, reg_wr_addr}, 32'd0);
        check("mid_rst_wr_data", {24'b0, reg_wr_data}, 32'd0);
        check("mid_rst_oe", {31'b0, spi_bus.spi_do_oe}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);
        clock_bits(24'h800102, 24, 1'b0);
        wait_clk(16);
        spi_bus.spi_enb = 1'b1;
        wait_clk(32);
        usr_read(10'h155, 8'h00);
        usr_read(10'h010, 8'h00);
        usr_read(10'h001, 8'h00);
        wr_q.push_back({10'h002, 8'h33});
        spi_frame(24'h800233, 24, 1'b0);
        usr_read(10'h002, 8'h33);

        wait_clk(20);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("bit_q_drained", bit_q.size(), 32'd0);
        check("ur_q_drained", ur_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
